// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg
//   Shared constants and types for the serial program loader.
//   LOADER_SYNC : byte that opens every program frame
//   INSTR_W     : instruction word width, equal to the ROM data width (3 bytes)
//   load_state_e: frame FSM states
package uart_loader_pkg;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;
  localparam int         INSTR_W     = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_SUM  = 2'd3
  } load_state_e;

endpackage

// File: rtl/uart_loader_uart_rx.sv
// uart_rx
//   8N1 byte receiver with a 2-flop input synchronizer.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   rx         : asynchronous serial input, idle high, LSB first
//   data       : last received byte, valid while byte_valid is high
//   byte_valid : one-cycle pulse, byte received with a high stop bit
//   frame_err  : one-cycle pulse, stop bit sampled low (no byte delivered)
module uart_rx #(
  parameter int CLK_HZ = 27_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV + 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic             meta_q, sync_q, prev_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // The start bit is re-checked half a bit after the edge; every later
  // sample lands a full bit period after the previous one, i.e. mid-bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // Returning to idle at mid-stop lets the next start edge be caught
        // without waiting for the end of the stop bit.
        if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync_q) valid_d = 1'b1;
          else        ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= rx;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data       = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_loader.sv
// uart_loader
//   Receives a framed program image (A5, LEN, LEN*3 payload bytes, XOR SUM)
//   over UART and writes 24-bit words into the instruction ROM.
//   clk, rst     : system clock, asynchronous active-low reset
//   uart_rx      : serial input
//   rom_w_enable : one-cycle ROM write strobe
//   rom_w_addr   : ROM word address
//   rom_w_data   : instruction word
//   cpu_hold     : holds the core in reset during a load or after a failure
//   busy         : frame FSM is not idle
//   error        : sticky failure flag, cleared by the next sync byte
//   loaded       : one-cycle pulse on a verified load
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_HZ       = 27_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 2000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rx,
  output logic               rom_w_enable,
  output logic [7:0]         rom_w_addr,
  output logic [INSTR_W-1:0] rom_w_data,
  output logic               cpu_hold,
  output logic               busy,
  output logic               error,
  output logic               loaded
);

  localparam int TMO_CYC = TIMEOUT_BITS * (CLK_HZ / BAUD);
  localparam int TMO_W   = $clog2(TMO_CYC + 1);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (uart_rx),
    .data      (rx_data),
    .byte_valid(rx_valid),
    .frame_err (rx_ferr)
  );

  load_state_e        state_q, state_d;
  logic [8:0]         count_q, count_d;
  logic [1:0]         idx_q, idx_d;
  logic [15:0]        asm_q, asm_d;
  logic [7:0]         xor_q, xor_d;
  logic [7:0]         addr_q, addr_d;
  logic               wen_q, wen_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               hold_q, hold_d;
  logic               err_q, err_d;
  logic               loaded_q, loaded_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               tmo_expired;

  assign tmo_expired = (state_q != ST_IDLE) && (tmo_q == TMO_W'(TMO_CYC));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    xor_d    = xor_q;
    addr_d   = addr_q;
    wen_d    = 1'b0;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    err_d    = err_q;
    loaded_d = 1'b0;
    tmo_d    = tmo_q;

    // Address advances the cycle after the strobe so it is stable while
    // the strobe is high.
    if (wen_q) addr_d = addr_q + 8'd1;

    if (state_q == ST_IDLE || rx_valid) tmo_d = '0;
    else if (!tmo_expired)              tmo_d = tmo_q + 1'b1;

    if (state_q == ST_IDLE) begin
      if (rx_valid && rx_data == LOADER_SYNC) begin
        state_d = ST_LEN;
        hold_d  = 1'b1;
        err_d   = 1'b0;
        idx_d   = '0;
        addr_d  = '0;
        xor_d   = '0;
      end
    end else if (rx_ferr || tmo_expired) begin
      // Any partial word in asm_q is simply discarded.
      state_d = ST_IDLE;
      err_d   = 1'b1;
      hold_d  = 1'b1;
    end else if (rx_valid) begin
      if (state_q == ST_LEN) begin
        count_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
        idx_d   = '0;
        state_d = ST_DATA;
      end else if (state_q == ST_DATA) begin
        xor_d = xor_q ^ rx_data;
        if (idx_q == 2'd2) begin
          wen_d   = 1'b1;
          wdata_d = {asm_q, rx_data};
          idx_d   = '0;
          count_d = count_q - 9'd1;
          if (count_q == 9'd1) state_d = ST_SUM;
        end else begin
          asm_d = {asm_q[7:0], rx_data};
          idx_d = idx_q + 2'd1;
        end
      end else begin
        if (rx_data == xor_q) begin
          loaded_d = 1'b1;
          hold_d   = 1'b0;
        end else begin
          err_d  = 1'b1;
          hold_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      asm_q    <= '0;
      xor_q    <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      asm_q    <= asm_d;
      xor_q    <= xor_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
      tmo_q    <= tmo_d;
    end
  end

  assign rom_w_enable = wen_q;
  assign rom_w_addr   = addr_q;
  assign rom_w_data   = wdata_q;
  assign cpu_hold     = hold_q;
  assign busy         = (state_q != ST_IDLE);
  assign error        = err_q;
  assign loaded       = loaded_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader
//   Scoreboard bench for uart_loader. Frames are built from random or fixed
//   payloads; the expected ROM writes and loaded pulses are derived from the
//   frame contents and queued, and a monitor pops them as the DUT emits them.
module tb_uart_loader;

  // Scaled-down timing keeps the full 256-word image short: bit period 6.
  localparam int CLK_HZ       = 600_000;
  localparam int BAUD         = 100_000;
  localparam int DIV          = CLK_HZ / BAUD;
  localparam int TIMEOUT_BITS = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uart_rx = 1'b1;
  logic        rom_w_enable;
  logic [7:0]  rom_w_addr;
  logic [23:0] rom_w_data;
  logic        cpu_hold, busy, error, loaded;

  typedef struct {
    bit          isLoad;
    logic [7:0]  addr;
    logic [23:0] data;
  } evT;

  evT         expQ[$];
  logic [7:0] payload[$];
  int         checks = 0;
  int         failures = 0;

  uart_loader #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .rom_w_enable(rom_w_enable),
    .rom_w_addr  (rom_w_addr),
    .rom_w_data  (rom_w_data),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .error       (error),
    .loaded      (loaded)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Monitor: whenever the DUT strobes a write or a loaded pulse, pop the
  // oldest expected event and compare it against what the DUT presents.
  always @(negedge clk) begin
    evT e;
    if (rst && (rom_w_enable || loaded)) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_event actual=we%0b/ld%0b addr=%0h data=%0h required=none",
                 rom_w_enable, loaded, rom_w_addr, rom_w_data);
      end else begin
        e = expQ.pop_front();
        if (e.isLoad) begin
          checkOutput("loaded_event", {31'd0, loaded}, 32'd1);
          checkOutput("hold_at_loaded", {31'd0, cpu_hold}, 32'd0);
        end else begin
          checkOutput("write_event", {31'd0, rom_w_enable}, 32'd1);
          checkOutput("write_addr", {24'd0, rom_w_addr}, {24'd0, e.addr});
          checkOutput("write_data", {8'd0, rom_w_data}, {8'd0, e.data});
          checkOutput("busy_during_write", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    repeat (95000) @(posedge clk);
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Send one 8N1 byte; stopOk=0 drives a low stop bit.
  task automatic applyStimulus(input logic [7:0] b, input bit stopOk);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stopOk;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic settle();
    repeat (3 * DIV) @(negedge clk);
  endtask

  task automatic checkIdleState(input string tag, input bit expErr, input bit expHold);
    checkOutput({tag, "_drained"}, expQ.size(), 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_error"}, {31'd0, error}, {31'd0, expErr});
    checkOutput({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, expHold});
  endtask

  task automatic randomPayload(input int words);
    payload.delete();
    for (int i = 0; i < 3 * words; i++) payload.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference model: words are consecutive big-endian byte triples at
  // addresses 0,1,2..; the checksum is the XOR of the payload. corrupt is
  // XORed into the transmitted SUM so any nonzero value must fail the load.
  task automatic runFrame(input string tag, input logic [7:0] lenByte,
                          input logic [7:0] corrupt, input bit glitch);
    int         words;
    logic [7:0] sum;
    evT         e;
    words = (lenByte == 8'd0) ? 256 : int'(lenByte);
    sum = 8'd0;
    foreach (payload[i]) sum ^= payload[i];
    for (int w = 0; w < words; w++) begin
      e.isLoad = 1'b0;
      e.addr   = 8'(w % 256);
      e.data   = {payload[3*w], payload[3*w+1], payload[3*w+2]};
      expQ.push_back(e);
    end
    if (corrupt == 8'd0) begin
      e.isLoad = 1'b1;
      e.addr   = 8'd0;
      e.data   = 24'd0;
      expQ.push_back(e);
    end
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(lenByte, 1'b1);
    if (glitch) begin
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (2 * DIV) @(negedge clk);
    end
    foreach (payload[i]) applyStimulus(payload[i], 1'b1);
    applyStimulus(sum ^ corrupt, 1'b1);
    settle();
    checkIdleState(tag, corrupt != 8'd0, corrupt != 8'd0);
  endtask

  initial begin
    evT e;
    #1;
    // Reset values.
    checkOutput("rst_we", {31'd0, rom_w_enable}, 32'd0);
    checkOutput("rst_addr", {24'd0, rom_w_addr}, 32'd0);
    checkOutput("rst_data", {8'd0, rom_w_data}, 32'd0);
    checkOutput("rst_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_error", {31'd0, error}, 32'd0);
    checkOutput("rst_loaded", {31'd0, loaded}, 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Nominal load.
    payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    runFrame("nominal", 8'h02, 8'h00, 1'b0);

    // Stray byte in IDLE.
    applyStimulus(8'h3C, 1'b1);
    settle();
    checkIdleState("stray", 1'b0, 1'b0);

    // Bad checksum (SUM sent as 0x00), then recovery with a good frame.
    runFrame("badsum", 8'h02, 8'h77, 1'b0);
    runFrame("recover", 8'h02, 8'h00, 1'b0);

    // Framing error on the 4th payload byte: only word 0 is written.
    e = '{1'b0, 8'h00, 24'h112233};
    expQ.push_back(e);
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h02, 1'b1);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h44, 1'b0);
    settle();
    checkIdleState("framing", 1'b1, 1'b1);

    // Timeout after a partial word.
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'hAA, 1'b1);
    checkOutput("timeout_busy_before", {31'd0, busy}, 32'd1);
    checkOutput("timeout_error_cleared", {31'd0, error}, 32'd0);
    repeat ((TIMEOUT_BITS + 2) * DIV) @(negedge clk);
    checkIdleState("timeout", 1'b1, 1'b1);

    // Stray byte while in error leaves the error standing.
    applyStimulus(8'h3C, 1'b1);
    settle();
    checkIdleState("stray_err", 1'b1, 1'b1);

    // Reset mid-DATA after one word has been written.
    e = '{1'b0, 8'h00, 24'h112233};
    expQ.push_back(e);
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h02, 1'b1);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h44, 1'b1);
    checkOutput("midload_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("midload_addr", {24'd0, rom_w_addr}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_addr", {24'd0, rom_w_addr}, 32'd0);
    checkOutput("async_rst_data", {8'd0, rom_w_data}, 32'd0);
    checkOutput("async_rst_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_rst_error", {31'd0, error}, 32'd0);
    checkOutput("async_rst_drained", expQ.size(), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    runFrame("after_reset", 8'h02, 8'h00, 1'b0);

    // Short glitch inside a frame must not be taken as a byte.
    randomPayload(1);
    runFrame("glitch", 8'h01, 8'h00, 1'b1);

    // Randomized frames, some with a corrupted checksum.
    for (int f = 0; f < 5; f++) begin
      int len;
      logic [7:0] corrupt;
      len = $urandom_range(1, 5);
      corrupt = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      randomPayload(len);
      runFrame("random", 8'(len), corrupt, 1'b0);
    end

    // Full 256-word image; address wraps back to 0 afterwards.
    randomPayload(256);
    runFrame("full_image", 8'h00, 8'h00, 1'b0);
    checkOutput("full_addr_wrap", {24'd0, rom_w_addr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Serial program loader upstream of the instruction ROM. Receives a framed program image on a UART pin, assembles 24-bit instruction words, and writes them into the ROM through a dedicated write port. While a load is in progress it holds the CPU core in reset. The top level releases the core only after the image checksum verifies.

## Interface
- `CLK_HZ`, 27_000_000: system clock frequency.
- `BAUD`, 115200: UART bit rate; bit period `DIV = CLK_HZ/BAUD` (integer, truncated; 234 at defaults).
- `TIMEOUT_BITS`, 2000: maximum inter-byte gap, in bit periods, inside a frame.
- `clk`, in, 1: system clock; single clock domain.
- `rst`, in, 1: reset, asynchronous, active-low.
- `uart_rx`, in, 1: asynchronous serial input, idle high, 8N1, LSB first.
- `rom_w_enable`, out, 1: one-cycle write strobe to the ROM.
- `rom_w_addr`, out, 8: ROM word address.
- `rom_w_data`, out, 24: instruction word.
- `cpu_hold`, out, 1: high while a load is in progress or a load has failed. Top ANDs `!cpu_hold` into the core reset.
- `busy`, out, 1: high in any state other than IDLE.
- `error`, out, 1: sticky failure flag.
- `loaded`, out, 1: one-cycle pulse on a verified load.

## Operation
- **Frame format:** `0xA5`, then `LEN`, then `LEN`×3 payload bytes, then `SUM`.
  - `LEN = 0` means 256 words.
  - Each word is sent big-endian: the first byte is bits [23:16].
  - `SUM` is the XOR of all payload bytes. `0xA5` and `LEN` are excluded.
- **Byte receiver:**
  - `uart_rx` passes through a 2-flop synchronizer.
  - A falling edge starts a byte. The start bit is re-checked low at `DIV/2`. If it is high, the byte is a glitch: drop it and re-arm.
  - Data bits are sampled every `DIV` cycles after that point. The stop bit is sampled the same way.
  - Stop bit high: raise `byte_valid` for one cycle with the byte.
  - Stop bit low: raise `frame_err` for one cycle and output no byte.
- **Frame FSM states:** IDLE, LEN, DATA, SUM.
  - **IDLE:** a byte equal to `0xA5` moves to LEN. On that move: set `cpu_hold=1`, clear `error`, reset the word counter and address to 0, and clear the running XOR. Any other byte is ignored.
  - **LEN:** latch the count (0 maps to 256) and move to DATA.
  - **DATA:** shift each byte into a 24-bit assembly register and XOR it into the checksum. On the 3rd byte of a word: pulse `rom_w_enable`, increment the address (8-bit wrap, 255→0), and decrement the count. When the count reaches 0, move to SUM.
  - **SUM:** if the byte matches the XOR, pulse `loaded` and clear `cpu_hold`. If not, set `error=1` and keep `cpu_hold=1`. Either way return to IDLE.
- **Aborts:** a `frame_err` or an inter-byte timeout in LEN, DATA or SUM sets `error=1`, keeps `cpu_hold=1`, and returns to IDLE. A partially received word is not written.
- **Recovery:** after an error the core stays held until a later frame verifies. The ROM holds a partial image.

## Timing
- **Reset values:** all outputs are 0, the FSM is in IDLE, and the receiver is idle. Reset asserted mid-load abandons the frame and releases `cpu_hold`. The ROM keeps whatever words were already written.
- **Byte latency:** `byte_valid` rises 2 (synchronizer) + `DIV/2` + 9·`DIV` cycles after the start-bit falling edge on the pin, ±1 cycle.
- **ROM write:** `rom_w_enable`, `rom_w_addr` and `rom_w_data` are registered. They appear in the cycle after the `byte_valid` of the word's 3rd byte. Address and data are stable while the strobe is high. The address increments in the following cycle.
- **Verified load:** `loaded` and the fall of `cpu_hold` occur in the cycle after the `SUM` byte's `byte_valid`.
- **Timeout:** a counter of `TIMEOUT_BITS·DIV` cycles restarts on every `byte_valid` and runs only in LEN, DATA and SUM. Expiry aborts the frame on the following cycle.
- **Concurrency:** at most one `rom_w_enable` per three bytes. Writes never occur while the FSM is in IDLE.

## Structure
- **`uart_loader_pkg`:**
  - Constants: `LOADER_SYNC` = 8'hA5, and `INSTR_W` = 24 (must match the ROM data width, 8*3).
  - Typedef: the FSM state enum.
- **Sub-module `uart_rx`:**
  - Parameters: `CLK_HZ`, `BAUD`.
  - Ports: `clk`, `rst`, `rx`, `data[7:0]`, `byte_valid`, `frame_err`.
  - It contains the synchronizer and bit timing.
  - The frame FSM, checksum and timeout stay in `uart_loader`.

## Test plan
- **Nominal load:** `A5 02 11 22 33 44 55 66 SUM=0x77` → writes `0x112233`@0 and `0x445566`@1, then one `loaded` pulse; `cpu_hold` goes 1 then 0; `error=0`.
- **Bad checksum:** the same frame with `SUM=0x00` → both writes occur, `error=1`, `cpu_hold` stays 1, no `loaded` pulse. A following valid frame clears `error` and releases hold.
- **Framing error:** the 4th byte is sent with a low stop bit → abort, `error=1`, no write at address 1, FSM in IDLE.
- **Full image:** `LEN=0x00` with 768 bytes → 256 writes at addresses 0..255; the address wraps to 0 afterward; `loaded` only after `SUM`.
- **Timeout and stray bytes:**
  - `A5 01 AA` then silence for `TIMEOUT_BITS` bit periods → `error=1`, no write.
  - A stray byte `0x3C` in IDLE → no state change.
- **Reset and glitch:**
  - `rst` pulsed low during DATA → all outputs return to 0 asynchronously, and a following frame loads normally.
  - A 50-cycle low glitch on `uart_rx` → no byte is received.
